norm_bram_writer: RTL and testbench
===================================

# norm_bram_writer

Write-side controller for the normalization/pooling line buffer. It accepts a raster-order pixel stream from the convolution stage and scatters each pixel into one of four BRAM banks using the 2x2 quadrant layout that the normalization BRAM reader consumes. It then hands the filled buffer to the reader over the bram_start_reading / bram_start_ack handshake, and holds off new input until the reader reports the frame drained.

## Interface
- PIXEL_WIDTH, 16, pixel word width
- BRAM_ADDR_WIDTH, 11, per-bank address width
- IMAGE_SIZE_WIDTH, 9, width of image dimension fields
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- layer_start  in  1  one-cycle config strobe, honoured only in IDLE
- image_width  in  IMAGE_SIZE_WIDTH  frame width W, latched on layer_start
- image_hight  in  IMAGE_SIZE_WIDTH  frame height H, latched on layer_start
- pixel_data_in  in  PIXEL_WIDTH  input pixel
- pixel_data_valid_in  in  1  input beat valid
- pixel_data_last_in  in  1  final pixel of frame
- pixel_data_ready_out  out  1  input ready; beat accepted when valid && ready
- bram_wr_en_1..bram_wr_en_4  out  1 each  bank write enables, at most one high per cycle
- bram_wr_addr  out  BRAM_ADDR_WIDTH  shared write address
- bram_wr_data  out  PIXEL_WIDTH  shared write data
- bram_start_reading  out  1  buffer-full request to the reader
- bram_start_ack  in  1  reader acceptance pulse
- bram_read_done  in  1  reader's last-pixel pulse; buffer is free again
- config_error  out  1  sticky: rejected W/H
- frame_error  out  1  sticky: last_in mismatch

## Operation
- Layout for pixel (r,c), 0-based: bank = 1 + 2*r[0] + c[0] (bank1 even/even, bank2 even-row/odd-col, bank3 odd-row/even-col, bank4 odd/odd); addr = (r>>1)*(W>>1) + (c>>1).
- Address generation is incremental with no multiplier: row_base register; col_addr = row_base + (c>>1); row_base += W>>1 after each odd row.
- States:
  - IDLE: ready=0. On layer_start: W,H both even and ≥2 → latch W/H, clear counters, go to WRITE. Otherwise set config_error and stay in IDLE.
  - WRITE: ready=1. Each accepted beat issues one write and advances c, wrapping at W-1 to c=0, r+1.
  - Accepted beat with r=H-1, c=W-1, or with last_in=1 → go to HANDOFF.
  - If the two conditions disagree (last_in early, or absent on the final pixel), set frame_error. Either one ends the frame.
  - HANDOFF: ready=0, bram_start_reading=1. On bram_start_ack=1 → go to DRAIN.
  - DRAIN: ready=0, start=0. On bram_read_done=1 → go to IDLE.
- bram_read_done or bram_start_ack outside its owning state is ignored.
- layer_start outside IDLE is ignored.
- config_error and frame_error clear only on reset, or on an accepted layer_start with valid W/H.
- Arithmetic is unsigned. Addresses beyond 2^BRAM_ADDR_WIDTH-1 are outside the design envelope, and the block does not check for them.

## Timing
- Reset (reset=0 at an edge): state=IDLE, all outputs 0, counters/row_base 0, error flags 0.
- Reset mid-frame or mid-handoff aborts immediately. bram_start_reading is 0 on the next cycle.
- Write latency 1: a beat accepted at edge N drives bram_wr_en_x/addr/data during cycle N+1 for exactly one cycle.
- pixel_data_ready_out is decoded from state. The final beat's accepting edge also leaves WRITE, so no extra beat is taken.
- bram_start_reading rises in the cycle after the final beat is accepted, coincident with the final write. The reader's input pipeline register guarantees that write completes before the first read.
- bram_start_reading is held until bram_start_ack is sampled high, and is low from the next cycle. The minimum high time is 1 cycle.
- After DRAIN→IDLE, a new layer_start is accepted the following cycle at the earliest.

## Test plan
- W=4,H=4, data=p (raster index 0..15), valid always high:
  - bank1 gets addr0..3 = 0,2,8,10
  - bank2 gets 1,3,9,11
  - bank3 gets 4,6,12,14
  - bank4 gets 5,7,13,15
  - ready drops after p15; start rises the same cycle as the p15 write.
- Same frame with valid toggled 1010 and with ready-gated gaps → identical bank contents; no write on idle cycles.
- Handoff: ack held low for 5 cycles → start high for all 5 cycles plus the ack cycle, then low. Ready stays 0 until the cycle after bram_read_done.
- W=4,H=4 with last_in at p9 → frame_error=1, start asserts after p9, p10+ not accepted. Second frame with last_in missing on p15 → frame_error=1, frame still ends at p15.
- layer_start with W=5,H=4, or with W=0 → config_error=1, state stays IDLE, ready=0. Valid W=2,H=2 afterwards clears the flag and writes one word to each bank at addr0.
- reset=0 during p6 of a 4x4 frame → all outputs 0 next cycle. New layer_start restarts at bank1 addr0.

Source files
------------

// File: rtl/norm_bram_writer.sv
// Write-side controller for the normalization line buffer.
// Scatters a raster pixel stream into four 2x2-quadrant BRAM banks.
module norm_bram_writer #(
   parameter int PIXEL_WIDTH      = 16,
   parameter int BRAM_ADDR_WIDTH  = 11,
   parameter int IMAGE_SIZE_WIDTH = 9
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        layer_start,
   input  logic [IMAGE_SIZE_WIDTH-1:0] image_width,
   input  logic [IMAGE_SIZE_WIDTH-1:0] image_hight,
   input  logic [PIXEL_WIDTH-1:0]      pixel_data_in,
   input  logic                        pixel_data_valid_in,
   input  logic                        pixel_data_last_in,
   output logic                        pixel_data_ready_out,
   output logic                        bram_wr_en_1,
   output logic                        bram_wr_en_2,
   output logic                        bram_wr_en_3,
   output logic                        bram_wr_en_4,
   output logic [BRAM_ADDR_WIDTH-1:0]  bram_wr_addr,
   output logic [PIXEL_WIDTH-1:0]      bram_wr_data,
   output logic                        bram_start_reading,
   input  logic                        bram_start_ack,
   input  logic                        bram_read_done,
   output logic                        config_error,
   output logic                        frame_error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_HANDOFF,
      S_DRAIN
   } state_t;

   localparam logic [IMAGE_SIZE_WIDTH-1:0] ONE = IMAGE_SIZE_WIDTH'(1);

   state_t                      state_q, state_d;
   logic [IMAGE_SIZE_WIDTH-1:0] w_q, w_d;
   logic [IMAGE_SIZE_WIDTH-1:0] h_q, h_d;
   logic [IMAGE_SIZE_WIDTH-1:0] r_q, r_d;
   logic [IMAGE_SIZE_WIDTH-1:0] c_q, c_d;
   logic [BRAM_ADDR_WIDTH-1:0]  row_base_q, row_base_d;
   logic [3:0]                  wr_en_q, wr_en_d;
   logic [BRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [PIXEL_WIDTH-1:0]      data_q, data_d;
   logic                        cfg_err_q, cfg_err_d;
   logic                        frm_err_q, frm_err_d;

   logic cfg_ok;
   logic last_col;
   logic final_px;

   assign cfg_ok = !image_width[0] && (image_width != '0) &&
                   !image_hight[0] && (image_hight != '0);
   assign last_col = (c_q == w_q - ONE);
   assign final_px = last_col && (r_q == h_q - ONE);

   // Next-state, counter walk and registered write-port decode
   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      h_d        = h_q;
      r_d        = r_q;
      c_d        = c_q;
      row_base_d = row_base_q;
      wr_en_d    = '0;
      addr_d     = addr_q;
      data_d     = data_q;
      cfg_err_d  = cfg_err_q;
      frm_err_d  = frm_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (layer_start) begin
               if (cfg_ok) begin
                  w_d        = image_width;
                  h_d        = image_hight;
                  r_d        = '0;
                  c_d        = '0;
                  row_base_d = '0;
                  cfg_err_d  = 1'b0;
                  frm_err_d  = 1'b0;
                  state_d    = S_WRITE;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (pixel_data_valid_in) begin
               wr_en_d[{r_q[0], c_q[0]}] = 1'b1;
               addr_d = row_base_q + BRAM_ADDR_WIDTH'(c_q >> 1);
               data_d = pixel_data_in;
               if (last_col) begin
                  c_d = '0;
                  r_d = r_q + ONE;
                  if (r_q[0])
                     row_base_d = row_base_q + BRAM_ADDR_WIDTH'(w_q >> 1);
               end else begin
                  c_d = c_q + ONE;
               end
               if (final_px || pixel_data_last_in)
                  state_d = S_HANDOFF;
               if (final_px != pixel_data_last_in)
                  frm_err_d = 1'b1;
            end
         end
         S_HANDOFF: begin
            if (bram_start_ack)
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (bram_read_done)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         w_q        <= '0;
         h_q        <= '0;
         r_q        <= '0;
         c_q        <= '0;
         row_base_q <= '0;
         wr_en_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         cfg_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_q        <= w_d;
         h_q        <= h_d;
         r_q        <= r_d;
         c_q        <= c_d;
         row_base_q <= row_base_d;
         wr_en_q    <= wr_en_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cfg_err_q  <= cfg_err_d;
         frm_err_q  <= frm_err_d;
      end
   end

   assign pixel_data_ready_out = (state_q == S_WRITE);
   assign bram_start_reading   = (state_q == S_HANDOFF);
   assign bram_wr_en_1         = wr_en_q[0];
   assign bram_wr_en_2         = wr_en_q[1];
   assign bram_wr_en_3         = wr_en_q[2];
   assign bram_wr_en_4         = wr_en_q[3];
   assign bram_wr_addr         = addr_q;
   assign bram_wr_data         = data_q;
   assign config_error         = cfg_err_q;
   assign frame_error          = frm_err_q;

endmodule

// File: tb/tb_norm_bram_writer.sv
// Directed bench for norm_bram_writer.
// Bank writes are captured into shadow memories and compared to constants.
module tb_norm_bram_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        layer_start = 1'b0;
   logic [8:0]  image_width = '0;
   logic [8:0]  image_hight = '0;
   logic [15:0] pixel_data_in = '0;
   logic        pixel_data_valid_in = 1'b0;
   logic        pixel_data_last_in = 1'b0;
   logic        pixel_data_ready_out;
   logic        bram_wr_en_1, bram_wr_en_2, bram_wr_en_3, bram_wr_en_4;
   logic [10:0] bram_wr_addr;
   logic [15:0] bram_wr_data;
   logic        bram_start_reading;
   logic        bram_start_ack = 1'b0;
   logic        bram_read_done = 1'b0;
   logic        config_error;
   logic        frame_error;

   int nvec = 0;
   int nmis = 0;
   int wcnt = 0;
   int multi = 0;
   logic [15:0] mem [4][16];

   // 4x4 raster index expected at each bank address
   int exp44 [4][4] = '{'{0, 2, 8, 10}, '{1, 3, 9, 11},
                        '{4, 6, 12, 14}, '{5, 7, 13, 15}};

   always #5 clk = ~clk;

   norm_bram_writer dut (
      .clk                  (clk),
      .reset                (reset),
      .layer_start          (layer_start),
      .image_width          (image_width),
      .image_hight          (image_hight),
      .pixel_data_in        (pixel_data_in),
      .pixel_data_valid_in  (pixel_data_valid_in),
      .pixel_data_last_in   (pixel_data_last_in),
      .pixel_data_ready_out (pixel_data_ready_out),
      .bram_wr_en_1         (bram_wr_en_1),
      .bram_wr_en_2         (bram_wr_en_2),
      .bram_wr_en_3         (bram_wr_en_3),
      .bram_wr_en_4         (bram_wr_en_4),
      .bram_wr_addr         (bram_wr_addr),
      .bram_wr_data         (bram_wr_data),
      .bram_start_reading   (bram_start_reading),
      .bram_start_ack       (bram_start_ack),
      .bram_read_done       (bram_read_done),
      .config_error         (config_error),
      .frame_error          (frame_error)
   );

   // Capture bank writes into shadow memories
   always @(negedge clk) begin
      int ones;
      ones = int'(bram_wr_en_1) + int'(bram_wr_en_2) +
             int'(bram_wr_en_3) + int'(bram_wr_en_4);
      if (ones > 1) multi++;
      wcnt += ones;
      if (bram_wr_en_1) mem[0][bram_wr_addr[3:0]] = bram_wr_data;
      if (bram_wr_en_2) mem[1][bram_wr_addr[3:0]] = bram_wr_data;
      if (bram_wr_en_3) mem[2][bram_wr_addr[3:0]] = bram_wr_data;
      if (bram_wr_en_4) mem[3][bram_wr_addr[3:0]] = bram_wr_data;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_mem();
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < 16; a++)
            mem[b][a] = 16'hffff;
      wcnt = 0;
   endtask

   task automatic cfg(input int w, input int h);
      @(negedge clk);
      layer_start = 1'b1;
      image_width = 9'(w);
      image_hight = 9'(h);
      @(negedge clk);
      layer_start = 1'b0;
   endtask

   // Present pixels 0..npix-1; mode 1 toggles valid; stalls while not ready
   task automatic send(input int npix, input int last_idx, input int mode);
      int p;
      int cyc;
      p = 0;
      cyc = 0;
      while (p < npix && cyc < 200) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         pixel_data_valid_in = (mode == 1) ? cyc[0] : 1'b1;
         pixel_data_in = 16'(p);
         pixel_data_last_in = (p == last_idx);
         if (pixel_data_valid_in && pixel_data_ready_out) p++;
      end
      if (p < npix) chk("send_timeout", p, npix);
   endtask

   task automatic idle_in();
      pixel_data_valid_in = 1'b0;
      pixel_data_last_in = 1'b0;
   endtask

   task automatic handoff();
      @(negedge clk);
      bram_start_ack = 1'b1;
      @(negedge clk);
      bram_start_ack = 1'b0;
      bram_read_done = 1'b1;
      @(negedge clk);
      bram_read_done = 1'b0;
   endtask

   task automatic chk44(input string tag);
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < 4; a++)
            chk($sformatf("%s_b%0d_a%0d", tag, b + 1, a), mem[b][a],
                exp44[b][a]);
      chk({tag, "_wcnt"}, wcnt, 16);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", pixel_data_ready_out, 0);
      chk("rst_start", bram_start_reading, 0);
      chk("rst_wren", {bram_wr_en_4, bram_wr_en_3, bram_wr_en_2,
                       bram_wr_en_1}, 0);
      chk("rst_addr", bram_wr_addr, 0);
      chk("rst_errs", {config_error, frame_error}, 0);
      reset = 1'b1;

      // Frame 1: 4x4, valid always high
      clr_mem();
      cfg(4, 4);
      chk("f1_ready", pixel_data_ready_out, 1);
      send(16, 15, 0);
      @(negedge clk);
      idle_in();
      chk("f1_last_wr", bram_wr_en_4, 1);
      chk("f1_last_dat", bram_wr_data, 15);
      chk("f1_start", bram_start_reading, 1);
      chk("f1_ready_lo", pixel_data_ready_out, 0);
      // Ack held low for five cycles
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("f1_start_hold", bram_start_reading, 1);
      end
      bram_start_ack = 1'b1;
      chk("f1_start_ack", bram_start_reading, 1);
      @(negedge clk);
      bram_start_ack = 1'b0;
      chk("f1_start_off", bram_start_reading, 0);
      chk("f1_drain_rdy", pixel_data_ready_out, 0);
      chk44("f1");
      chk("f1_frm_err", frame_error, 0);
      layer_start = 1'b1;
      image_width = 9'd4;
      image_hight = 9'd4;
      @(negedge clk);
      layer_start = 1'b0;
      chk("f1_drain_ls", pixel_data_ready_out, 0);
      bram_read_done = 1'b1;
      @(negedge clk);
      bram_read_done = 1'b0;
      chk("f1_idle_rdy", pixel_data_ready_out, 0);

      // Frame 2: valid toggling, identical contents
      clr_mem();
      cfg(4, 4);
      send(16, 15, 1);
      @(negedge clk);
      idle_in();
      repeat (2) @(negedge clk);
      chk44("f2");
      handoff();

      // Frame 3: valid raised before layer_start (ready-gated gap)
      clr_mem();
      pixel_data_valid_in = 1'b1;
      pixel_data_in = 16'd0;
      repeat (2) @(negedge clk);
      chk("f3_gap_nowr", wcnt, 0);
      cfg(4, 4);
      send(16, 15, 0);
      @(negedge clk);
      idle_in();
      repeat (2) @(negedge clk);
      chk44("f3");
      handoff();

      // Frame 4: last_in early at p9
      clr_mem();
      cfg(4, 4);
      send(10, 9, 0);
      @(negedge clk);
      pixel_data_in = 16'd10;
      pixel_data_last_in = 1'b0;
      chk("f4_start", bram_start_reading, 1);
      chk("f4_last_dat", bram_wr_data, 9);
      chk("f4_frm_err", frame_error, 1);
      repeat (3) @(negedge clk);
      idle_in();
      chk("f4_wcnt", wcnt, 10);
      handoff();

      // Frame 5: last_in missing on p15
      clr_mem();
      cfg(4, 4);
      chk("f5_err_clr", frame_error, 0);
      send(16, -1, 0);
      @(negedge clk);
      idle_in();
      chk("f5_start", bram_start_reading, 1);
      chk("f5_frm_err", frame_error, 1);
      @(negedge clk);
      chk("f5_wcnt", wcnt, 16);
      handoff();

      // Rejected configurations
      cfg(5, 4);
      chk("cfg_w5_err", config_error, 1);
      chk("cfg_w5_rdy", pixel_data_ready_out, 0);
      cfg(0, 4);
      chk("cfg_w0_err", config_error, 1);
      chk("cfg_w0_rdy", pixel_data_ready_out, 0);

      // Valid 2x2 clears the flag
      clr_mem();
      cfg(2, 2);
      chk("cfg_ok_clr", config_error, 0);
      send(4, 3, 0);
      @(negedge clk);
      idle_in();
      @(negedge clk);
      for (int b = 0; b < 4; b++)
         chk($sformatf("f22_b%0d", b + 1), mem[b][0], b);
      chk("f22_wcnt", wcnt, 4);
      handoff();

      // Reset during p6
      clr_mem();
      cfg(4, 4);
      send(6, -1, 0);
      @(negedge clk);
      pixel_data_in = 16'd6;
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_wren", {bram_wr_en_4, bram_wr_en_3, bram_wr_en_2,
                        bram_wr_en_1}, 0);
      chk("mrst_addr", bram_wr_addr, 0);
      chk("mrst_data", bram_wr_data, 0);
      chk("mrst_ready", pixel_data_ready_out, 0);
      chk("mrst_start", bram_start_reading, 0);
      reset = 1'b1;
      idle_in();
      clr_mem();
      cfg(4, 4);
      pixel_data_valid_in = 1'b1;
      pixel_data_in = 16'h00ab;
      @(negedge clk);
      idle_in();
      chk("rst2_en1", bram_wr_en_1, 1);
      chk("rst2_addr", bram_wr_addr, 0);
      chk("rst2_data", bram_wr_data, 16'h00ab);

      chk("onehot", multi, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
